// File: rtl/cla_addsub_if.sv
// Valid/ready operand and result channels of the pipelined CLA adder/subtractor.
interface cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined adder/subtractor: each stage adds one WIDTH/STAGES slice with a two-level
// carry-lookahead network; the slice carry is registered into the next stage.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  cla_addsub_if.slave  bus
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;

  generate
    if (STAGES < 1 || (WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_cfg
      $error("cla_addsub_pipe: WIDTH must be a multiple of STAGES*GROUP");
    end
  endgenerate

  // Returns {carry into slice MSB, slice carry-out, slice sum}.
  function automatic logic [SLICE+1:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             cin);
    logic [SLICE-1:0] p, g;
    logic [NGRP-1:0]  gp, gg;
    logic [NGRP:0]    gc;
    logic [SLICE:0]   c;
    logic             t;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
    // Second level: every group carry is a flat sum of products from the slice carry-in.
    for (int j = 0; j <= NGRP; j++) begin
      t = cin;
      for (int k = 0; k < j; k++) t = t & gp[k];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int k = i + 1; k < j; k++) t = t & gp[k];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        t = gc[j];
        for (int k = 0; k < i; k++) t = t & p[j*GROUP+k];
        c[j*GROUP+i] = t;
        for (int m = 0; m < i; m++) begin
          t = g[j*GROUP+m];
          for (int k = m + 1; k < i; k++) t = t & p[j*GROUP+k];
          c[j*GROUP+i] = c[j*GROUP+i] | t;
        end
      end
    end
    c[SLICE] = gc[NGRP];
    return {c[SLICE-1], c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             src_v   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_c   [STAGES];
  logic [SLICE+1:0] res     [STAGES];
  logic             advance;

  always_comb begin
    advance    = !vld_q[STAGES-1] || bus.out_ready;
    // Op bit 0 selects inversion of b; op bit 1 selects the external carry-in.
    src_v[0]   = bus.in_valid;
    src_a[0]   = bus.in_a;
    src_b[0]   = bus.in_b ^ {WIDTH{bus.in_op[0]}};
    src_sum[0] = '0;
    src_c[0]   = bus.in_op[1] ? bus.in_cin : bus.in_op[0];
    for (int s = 1; s < STAGES; s++) begin
      src_v[s]   = vld_q[s-1];
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_sum[s] = sum_q[s-1];
      src_c[s]   = c_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      res[s]   = cla_slice(src_a[s][s*SLICE +: SLICE], src_b[s][s*SLICE +: SLICE], src_c[s]);
      vld_d[s] = vld_q[s];
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
      sum_d[s] = sum_q[s];
      c_d[s]   = c_q[s];
      if (advance) begin
        vld_d[s]                   = src_v[s];
        a_d[s]                     = src_a[s];
        b_d[s]                     = src_b[s];
        sum_d[s]                   = src_sum[s];
        sum_d[s][s*SLICE +: SLICE] = res[s][SLICE-1:0];
        c_d[s]                     = res[s][SLICE];
      end
    end
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (advance) begin
      ovf_d  = res[STAGES-1][SLICE+1] ^ res[STAGES-1][SLICE];
      zero_d = (sum_d[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= vld_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
        c_q[s]   <= c_d[s];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_sum   = sum_q[STAGES-1];
  assign bus.out_cout  = c_q[STAGES-1];
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_neg   = sum_q[STAGES-1][WIDTH-1];
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed vectors, random stream, stall and mid-flight reset.
module tb_cla_addsub_pipe;
  localparam int W      = 32;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         cin;
    res_t         exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   last_acc;
  int   last_fire;
  res_t drv_exp;
  int   drv_id;
  res_t sb_q[$];
  int   id_q[$];
  vec_t vecs[11];

  cla_addsub_if #(.WIDTH(W)) bus ();

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin);
    res_t         m;
    logic [W-1:0] bc;
    logic         c0;
    logic [W:0]   full;
    bc     = op[0] ? ~b : b;
    c0     = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bc} + {{W{1'b0}}, c0};
    m.sum  = full[W-1:0];
    m.cout = full[W];
    m.ovf  = (a[W-1] == bc[W-1]) && (full[W-1] != a[W-1]);
    m.zero = (full[W-1:0] == '0);
    m.neg  = full[W-1];
    return m;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic cin, input res_t exp, input int id);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_cin   = cin;
    drv_exp      = exp;
    drv_id       = id;
  endtask

  // One clock: sample handshakes after inputs settle, update scoreboard, move to next negedge.
  task automatic cycle();
    res_t got;
    res_t want;
    int   id;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      sb_q.push_back(drv_exp);
      id_q.push_back(drv_id);
      last_acc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("output_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        got  = '{bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg};
        want = sb_q.pop_front();
        id   = id_q.pop_front();
        chk($sformatf("result_%0d{sum,c,v,z,n}", id), 64'(got), 64'(want));
      end
      last_fire = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rcin;
    int           start;

    n_chk = 0; n_pass = 0; cyc = 0; last_acc = 0; last_fire = 0;
    drv_exp = '0; drv_id = 0;
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 2'b01, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[3]  = '{32'h0000_FFFF, 32'h0000_0000, 2'b10, 1'b1, '{32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{32'h0000_000A, 32'h0000_0003, 2'b11, 1'b0, '{32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 2'b01, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[9]  = '{32'h0000_0001, 32'h0000_0001, 2'b00, 1'b1, '{32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{32'h0000_0009, 32'h0000_0004, 2'b01, 1'b0, '{32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0}};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 2'b00; bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_sum", 64'(bus.out_sum), 64'd0);
    chk("reset_flags{c,v,z,n}", 64'({bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg}), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].exp, i);
      cycle();
    end
    drain();

    start = cyc;
    for (int i = 0; i < 100; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rop  = 2'($urandom_range(0, 3));
      rcin = 1'($urandom_range(0, 1));
      if (i % 10 == 3) ra = 32'hFFFF_FFFF;
      if (i % 10 == 7) rb = 32'h8000_0000;
      drive(ra, rb, rop, rcin, model(ra, rb, rop, rcin), 100 + i);
      cycle();
    end
    drain();
    chk("stream_accept_span", 64'(last_acc - start), 64'd99);
    chk("stream_output_span", 64'(last_fire - start), 64'(99 + STAGES));

    drive(32'h1234_5678, 32'h1111_1111, 2'b00, 1'b0, model(32'h1234_5678, 32'h1111_1111, 2'b00, 1'b0), 200);
    cycle();
    drive(32'h0000_0010, 32'h0000_0020, 2'b01, 1'b0, model(32'h0000_0010, 32'h0000_0020, 2'b01, 1'b0), 201);
    cycle();
    drive(32'hAAAA_AAAA, 32'h5555_5555, 2'b10, 1'b1, model(32'hAAAA_AAAA, 32'h5555_5555, 2'b10, 1'b1), 202);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out{sum,c,v,z,n}",
          64'({bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg}), 64'(sb_q[0]));
      cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    drain();

    drive(32'h0000_0001, 32'h0000_0002, 2'b00, 1'b0, model(32'h0000_0001, 32'h0000_0002, 2'b00, 1'b0), 300);
    cycle();
    drive(32'hFFFF_0000, 32'h0001_0000, 2'b00, 1'b0, model(32'hFFFF_0000, 32'h0001_0000, 2'b00, 1'b0), 301);
    cycle();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_out_sum", 64'(bus.out_sum), 64'd0);
    chk("midreset_flags{c,v,z,n}", 64'({bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg}), 64'd0);
    chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    sb_q.delete();
    id_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("no_stale_out_valid", 64'(bus.out_valid), 64'd0);
      cycle();
    end
    drive(32'h0000_0003, 32'h0000_0004, 2'b01, 1'b0, model(32'h0000_0003, 32'h0000_0004, 2'b01, 1'b0), 400);
    cycle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
